serial_subtractor_ctrl: RTL and testbench



---
 rtl/serial_subtractor_ctrl_if.sv | 33 +++
 rtl/serial_subtractor_ctrl.sv | 106 ++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_ctrl_if.sv
// Host-side bundle for serial_subtractor_ctrl: request, operands and results.
// ovf exists only when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtractor_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin_init;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] difference;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, bin_init,
`ifdef SERIAL_SUB_OVERFLOW_EN
    input  ovf,
`endif
    input  busy, done, difference, borrow_out
  );

  modport slave (
    input  start, a, b, bin_init,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output ovf,
`endif
    output busy, done, difference, borrow_out
  );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial a - b - bin_init using one full-subtractor cell, LSB first.
// Optional signed overflow flag under SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  serial_subtractor_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] x_q, y_q, res_q, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q, bout_q, busy_q, done_q;

  logic             d_bit, br_d, last_bit;
  logic [WIDTH-1:0] res_d;

  always_comb begin
    d_bit    = x_q[0] ^ y_q[0] ^ br_q;
    br_d     = (~x_q[0] & y_q[0]) | (~(x_q[0] ^ y_q[0]) & br_q);
    res_d    = {d_bit, res_q[WIDTH-1:1]};
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic a_msb_q, b_msb_q, ovf_q;
  assign bus.ovf = ovf_q;
`endif

  // NOTE: every state bit is cleared by reset, so an aborted operation leaves
  // nothing behind; non-blocking assignments keep the shift/borrow update
  // reading pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            x_q     <= bus.a;
            y_q     <= bus.b;
            br_q    <= bus.bin_init;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q <= bus.a[WIDTH-1];
            b_msb_q <= bus.b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          res_q <= res_d;
          x_q   <= x_q >> 1;
          y_q   <= y_q >> 1;
          br_q  <= br_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_bit) begin
            diff_q  <= res_d;
            bout_q  <= br_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
            // bin_init deliberately plays no part in the overflow term
            ovf_q   <= (a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q);
`endif
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.difference = diff_q;
  assign bus.borrow_out = bout_q;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for serial_subtractor_ctrl at WIDTH=8; ovf checked when
// SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor_ctrl;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_ctrl_if #(.WIDTH(W)) ifc ();

  serial_subtractor_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  exp_t         sb[$];
  int           checks     = 0;
  int           errors     = 0;
  int           done_total = 0;
  logic [W-1:0] last_diff  = '0;
  logic         last_bout  = 1'b0;
  logic         last_ovf   = 1'b0;

  function automatic exp_t model(input logic [W-1:0] av, bv, input logic binv);
    logic [W:0] full;
    exp_t       e;
    full   = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, binv};
    e.diff = full[W-1:0];
    e.bout = full[W];
    e.ovf  = (av[W-1] != bv[W-1]) && (full[W-1] != av[W-1]);
    return e;
  endfunction

  // Completion monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      checks++;
      if (ifc.busy && ifc.done) begin
        errors++;
        $display("FAIL busy_done_overlap: busy=%b done=%b at %0t", ifc.busy, ifc.done, $time);
      end
      if (ifc.done) begin
        done_total++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: done=1 with empty scoreboard at %0t", $time);
        end else begin
          e = sb.pop_front();
          if (ifc.difference !== e.diff || ifc.borrow_out !== e.bout) begin
            errors++;
            $display("FAIL result: got diff=%h bout=%b, expected diff=%h bout=%b",
                     ifc.difference, ifc.borrow_out, e.diff, e.bout);
          end
`ifdef SERIAL_SUB_OVERFLOW_EN
          checks++;
          if (ifc.ovf !== e.ovf) begin
            errors++;
            $display("FAIL ovf: got %b, expected %b", ifc.ovf, e.ovf);
          end
`endif
          last_diff = e.diff;
          last_bout = e.bout;
          last_ovf  = e.ovf;
        end
      end
    end
  end

  // One operation; optional start pulse at RUN index inject_at and during DONE.
  task automatic do_op(input logic [W-1:0] av, bv, input logic binv,
                       input int inject_at, input bit inject_done, output int busy_n);
    int           done_n;
    int           done_at;
    logic [W-1:0] hold_d;
    logic         hold_b;
    logic         hold_o;
    @(negedge clk);
    hold_d = last_diff;
    hold_b = last_bout;
    hold_o = last_ovf;
    ifc.a = av; ifc.b = bv; ifc.bin_init = binv; ifc.start = 1'b1;
    sb.push_back(model(av, bv, binv));
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.a = 8'($urandom); ifc.b = 8'($urandom); ifc.bin_init = 1'($urandom);
    busy_n = 0; done_n = 0; done_at = -1;
    for (int k = 0; k < 14; k++) begin
      if (ifc.busy) busy_n++;
      if (ifc.done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end else if (done_n == 0) begin
        checks++;
        if (ifc.difference !== hold_d || ifc.borrow_out !== hold_b) begin
          errors++;
          $display("FAIL hold: k=%0d got diff=%h bout=%b, expected diff=%h bout=%b",
                   k, ifc.difference, ifc.borrow_out, hold_d, hold_b);
        end
`ifdef SERIAL_SUB_OVERFLOW_EN
        checks++;
        if (ifc.ovf !== hold_o) begin
          errors++;
          $display("FAIL ovf_hold: k=%0d got %b, expected %b", k, ifc.ovf, hold_o);
        end
`endif
      end
      ifc.start = (k == inject_at) || (inject_done && ifc.done);
      if (k == inject_at) ifc.a = 8'hAA;
      @(negedge clk);
    end
    ifc.start = 1'b0;
    checks++;
    if (done_n !== 1) begin
      errors++;
      $display("FAIL done_pulses: got %0d, expected 1", done_n);
    end
    checks++;
    if (done_at !== W) begin
      errors++;
      $display("FAIL done_latency: got %0d, expected %0d", done_at, W);
    end
  endtask

  task automatic check_busy(input string name, input int busy_n);
    checks++;
    if (busy_n !== W) begin
      errors++;
      $display("FAIL %s_busy_cycles: got %0d, expected %0d", name, busy_n, W);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || ifc.difference !== '0 || ifc.borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL %s: got busy=%b done=%b diff=%h bout=%b, expected all 0",
               name, ifc.busy, ifc.done, ifc.difference, ifc.borrow_out);
    end
`ifdef SERIAL_SUB_OVERFLOW_EN
    checks++;
    if (ifc.ovf !== 1'b0) begin
      errors++;
      $display("FAIL %s_ovf: got %b, expected 0", name, ifc.ovf);
    end
`endif
  endtask

  task automatic test_reset();
    ifc.start = 1'b0; ifc.a = '0; ifc.b = '0; ifc.bin_init = 1'b0;
    #1 rst = 1'b1;
    #1 check_zero_outputs("reset_state");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_zero_outputs("idle_after_reset");
  endtask

  task automatic test_basic();
    int bn;
    do_op(8'h05, 8'h03, 1'b0, -1, 1'b0, bn);
    check_busy("basic", bn);
  endtask

  task automatic test_borrow();
    int bn;
    do_op(8'h03, 8'h05, 1'b0, -1, 1'b0, bn);
    check_busy("borrow", bn);
    do_op(8'h00, 8'h00, 1'b1, -1, 1'b0, bn);
    check_busy("bin_init", bn);
  endtask

  task automatic test_all_ones();
    int bn;
    do_op(8'hFF, 8'hFF, 1'b0, -1, 1'b0, bn);
    check_busy("all_ones", bn);
  endtask

  task automatic test_start_ignored();
    int bn;
    do_op(8'h10, 8'h01, 1'b0, 2, 1'b1, bn);
    check_busy("start_ignored", bn);
  endtask

  task automatic test_reset_mid();
    int d0;
    int bn;
    @(negedge clk);
    ifc.a = 8'h33; ifc.b = 8'h11; ifc.bin_init = 1'b0; ifc.start = 1'b1;
    sb.push_back(model(8'h33, 8'h11, 1'b0));
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ifc.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: got %b, expected 1", ifc.busy);
    end
    d0 = done_total;
    rst = 1'b1;
    #1 check_zero_outputs("reset_mid");
    sb.delete();
    last_diff = '0; last_bout = 1'b0; last_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (done_total !== d0) begin
      errors++;
      $display("FAIL aborted_done: got %0d done pulses, expected %0d", done_total, d0);
    end
    do_op(8'h20, 8'h10, 1'b0, -1, 1'b0, bn);
    check_busy("after_reset", bn);
  endtask

  task automatic test_overflow();
    int bn;
    do_op(8'h80, 8'h01, 1'b0, -1, 1'b0, bn);
    do_op(8'h7F, 8'hFF, 1'b0, -1, 1'b0, bn);
    do_op(8'h05, 8'h03, 1'b0, -1, 1'b0, bn);
    check_busy("overflow", bn);
  endtask

  task automatic test_random();
    int bn;
    for (int i = 0; i < 8; i++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), -1, 1'b0, bn);
      check_busy("random", bn);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_all_ones();
    test_start_ignored();
    test_reset_mid();
    test_overflow();
    test_random();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results never completed, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end
endmodule
